// File: rtl/doa_peak_select_pkg.sv
// rtl/doa_peak_select_pkg.sv - shared DOA types and width defaults
// Purpose: state encoding and width defaults common to the DOA search and select stages.
// Contents: doa_state_e (IDLE/SCAN/DONE), DOASEARCH_WIDTH_DEF, ANGLE_WIDTH_DEF.
package doa_peak_select_pkg;

  localparam int DOASEARCH_WIDTH_DEF = 48;
  localparam int ANGLE_WIDTH_DEF     = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } doa_state_e;

endpackage

// File: rtl/doa_rank_insert.sv
// rtl/doa_rank_insert.sv - combinational one-candidate insertion into a ranked slot file
// Purpose: computes the next contents of a NUM_SLOTS-deep ascending ranked list after
//          offering one candidate (stable: equal values stay behind earlier entries).
// Ports:
//   slot_val/slot_ang/slot_vld : current ranked slots (valid slots form a prefix)
//   cand_val/cand_ang          : candidate to insert
//   next_val/next_ang/next_vld : slot contents after insertion
module doa_rank_insert #(
  parameter int VALUE_WIDTH = 48,
  parameter int ANGLE_WIDTH = 10,
  parameter int NUM_SLOTS   = 2
) (
  input  logic signed [VALUE_WIDTH-1:0] slot_val [NUM_SLOTS],
  input  logic        [ANGLE_WIDTH-1:0] slot_ang [NUM_SLOTS],
  input  logic        [NUM_SLOTS-1:0]   slot_vld,
  input  logic signed [VALUE_WIDTH-1:0] cand_val,
  input  logic        [ANGLE_WIDTH-1:0] cand_ang,
  output logic signed [VALUE_WIDTH-1:0] next_val [NUM_SLOTS],
  output logic        [ANGLE_WIDTH-1:0] next_ang [NUM_SLOTS],
  output logic        [NUM_SLOTS-1:0]   next_vld
);

  localparam int PW = $clog2(NUM_SLOTS + 1);

  logic        [PW-1:0]          pos;
  logic signed [VALUE_WIDTH-1:0] shift_val [NUM_SLOTS];
  logic        [ANGLE_WIDTH-1:0] shift_ang [NUM_SLOTS];
  logic        [NUM_SLOTS-1:0]   shift_vld;

  always_comb begin
    // Counting "<=" rather than "<" places the candidate after equal values.
    pos = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slot_vld[i] && (slot_val[i] <= cand_val)) begin
        pos = pos + PW'(1);
      end
    end

    // Slot contents moved down by one; slot 0 has no predecessor.
    shift_val[0] = '0;
    shift_ang[0] = '0;
    shift_vld[0] = 1'b0;
    for (int i = 1; i < NUM_SLOTS; i++) begin
      shift_val[i] = slot_val[i-1];
      shift_ang[i] = slot_ang[i-1];
      shift_vld[i] = slot_vld[i-1];
    end

    // pos == NUM_SLOTS keeps every slot, i.e. the candidate is discarded.
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (PW'(i) < pos) begin
        next_val[i] = slot_val[i];
        next_ang[i] = slot_ang[i];
        next_vld[i] = slot_vld[i];
      end else if (PW'(i) == pos) begin
        next_val[i] = cand_val;
        next_ang[i] = cand_ang;
        next_vld[i] = 1'b1;
      end else begin
        next_val[i] = shift_val[i];
        next_ang[i] = shift_ang[i];
        next_vld[i] = shift_vld[i];
      end
    end
  end

endmodule

// File: rtl/doa_peak_select.sv
// rtl/doa_peak_select.sv - picks the NUM_SOURCES deepest MUSIC denominator minima
// Purpose: snapshots the local-minimum list on start_select, insertion-sorts one candidate
//          per clock into a ranked slot file, and publishes the K smallest values (ascending)
//          with their angles.
// Ports:
//   clk, rst (async, active-high), start_select (sampled in IDLE only)
//   local_min / local_min_angle / local_min_count : candidate list, entries 0..count-1
//   doa_value / doa_angle / doa_count             : results, updated only in DONE
//   busy (SCAN and DONE), select_done (one-cycle pulse in DONE)
module doa_peak_select
  import doa_peak_select_pkg::*;
#(
  parameter int DOASEARCH_WIDTH = DOASEARCH_WIDTH_DEF,
  parameter int LOCAL_MIN_DEPTH = 16,
  parameter int NUM_SOURCES     = 2,
  parameter int ANGLE_WIDTH     = ANGLE_WIDTH_DEF
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start_select,
  input  logic signed [DOASEARCH_WIDTH-1:0]       local_min       [LOCAL_MIN_DEPTH],
  input  logic        [ANGLE_WIDTH-1:0]           local_min_angle [LOCAL_MIN_DEPTH],
  input  logic        [$clog2(LOCAL_MIN_DEPTH)-1:0] local_min_count,
  output logic signed [DOASEARCH_WIDTH-1:0]       doa_value       [NUM_SOURCES],
  output logic        [ANGLE_WIDTH-1:0]           doa_angle       [NUM_SOURCES],
  output logic        [$clog2(NUM_SOURCES+1)-1:0] doa_count,
  output logic                                    busy,
  output logic                                    select_done
);

  localparam int CW  = $clog2(LOCAL_MIN_DEPTH);
  localparam int OCW = $clog2(NUM_SOURCES + 1);

  doa_state_e state;

  logic signed [DOASEARCH_WIDTH-1:0] snap_val [LOCAL_MIN_DEPTH];
  logic        [ANGLE_WIDTH-1:0]     snap_ang [LOCAL_MIN_DEPTH];
  logic        [CW-1:0]              snap_count;
  logic        [CW-1:0]              idx;

  logic signed [DOASEARCH_WIDTH-1:0] slot_val [NUM_SOURCES];
  logic        [ANGLE_WIDTH-1:0]     slot_ang [NUM_SOURCES];
  logic        [NUM_SOURCES-1:0]     slot_vld;

  logic signed [DOASEARCH_WIDTH-1:0] next_val [NUM_SOURCES];
  logic        [ANGLE_WIDTH-1:0]     next_ang [NUM_SOURCES];
  logic        [NUM_SOURCES-1:0]     next_vld;

  doa_rank_insert #(
    .VALUE_WIDTH (DOASEARCH_WIDTH),
    .ANGLE_WIDTH (ANGLE_WIDTH),
    .NUM_SLOTS   (NUM_SOURCES)
  ) u_rank_insert (
    .slot_val (slot_val),
    .slot_ang (slot_ang),
    .slot_vld (slot_vld),
    .cand_val (snap_val[idx]),
    .cand_ang (snap_ang[idx]),
    .next_val (next_val),
    .next_ang (next_ang),
    .next_vld (next_vld)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      snap_count  <= '0;
      slot_vld    <= '0;
      doa_count   <= '0;
      busy        <= 1'b0;
      select_done <= 1'b0;
      for (int i = 0; i < LOCAL_MIN_DEPTH; i++) begin
        snap_val[i] <= '0;
        snap_ang[i] <= '0;
      end
      for (int i = 0; i < NUM_SOURCES; i++) begin
        slot_val[i]  <= '0;
        slot_ang[i]  <= '0;
        doa_value[i] <= '0;
        doa_angle[i] <= '0;
      end
    end else begin
      select_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_select) begin
            // Snapshot so the caller may reuse its list while we scan.
            for (int i = 0; i < LOCAL_MIN_DEPTH; i++) begin
              snap_val[i] <= local_min[i];
              snap_ang[i] <= local_min_angle[i];
            end
            snap_count <= local_min_count;
            // Cleared slots keep unfilled outputs at zero.
            for (int i = 0; i < NUM_SOURCES; i++) begin
              slot_val[i] <= '0;
              slot_ang[i] <= '0;
            end
            slot_vld <= '0;
            idx      <= '0;
            busy     <= 1'b1;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (idx == snap_count) begin
            for (int i = 0; i < NUM_SOURCES; i++) begin
              doa_value[i] <= slot_vld[i] ? slot_val[i] : '0;
              doa_angle[i] <= slot_vld[i] ? slot_ang[i] : '0;
            end
            doa_count   <= (32'(snap_count) < 32'(NUM_SOURCES)) ? OCW'(snap_count)
                                                                : OCW'(NUM_SOURCES);
            select_done <= 1'b1;
            state       <= DONE;
          end else begin
            slot_val <= next_val;
            slot_ang <= next_ang;
            slot_vld <= next_vld;
            idx      <= idx + CW'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_doa_peak_select.sv
// tb/tb_doa_peak_select.sv - self-checking bench for doa_peak_select
module tb_doa_peak_select;

  localparam int W  = 48;
  localparam int D  = 16;
  localparam int K  = 2;
  localparam int AW = 10;

  logic                clk = 1'b0;
  logic                rst;
  logic                start_select;
  logic signed [W-1:0] lm [D];
  logic [AW-1:0]       la [D];
  logic [3:0]          lc;
  logic signed [W-1:0] doa_value [K];
  logic [AW-1:0]       doa_angle [K];
  logic [1:0]          doa_count;
  logic                busy;
  logic                select_done;

  always #5 clk = ~clk;

  doa_peak_select #(
    .DOASEARCH_WIDTH (W),
    .LOCAL_MIN_DEPTH (D),
    .NUM_SOURCES     (K),
    .ANGLE_WIDTH     (AW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start_select    (start_select),
    .local_min       (lm),
    .local_min_angle (la),
    .local_min_count (lc),
    .doa_value       (doa_value),
    .doa_angle       (doa_angle),
    .doa_count       (doa_count),
    .busy            (busy),
    .select_done     (select_done)
  );

  typedef struct packed {
    logic [W-1:0]  v0;
    logic [W-1:0]  v1;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [1:0]    c;
    logic [7:0]    lat;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: repeated minimum search, lowest index wins on ties.
  task automatic push_expected();
    exp_t e;
    bit   taken [D];
    int   best;
    e = '0;
    for (int i = 0; i < D; i++) taken[i] = 1'b0;
    for (int k = 0; k < K; k++) begin
      best = -1;
      for (int i = 0; i < int'(lc); i++)
        if (!taken[i] && (best < 0 || lm[i] < lm[best])) best = i;
      if (best >= 0) begin
        taken[best] = 1'b1;
        if (k == 0) begin e.v0 = lm[best]; e.a0 = la[best]; end
        else        begin e.v1 = lm[best]; e.a1 = la[best]; end
      end
    end
    e.c   = (int'(lc) < K) ? 2'(lc) : 2'(K);
    e.lat = 8'(int'(lc) + 2);
    exp_q.push_back(e);
  endtask

  task automatic fill_junk();
    for (int i = 0; i < D; i++) begin
      lm[i] = -48'sd999;
      la[i] = 10'd999;
    end
  endtask

  task automatic set_entry(input int i, input logic signed [W-1:0] v, input logic [AW-1:0] a);
    lm[i] = v;
    la[i] = a;
  endtask

  // disturb: pulse start and corrupt inputs mid-SCAN, and pulse start during DONE.
  task automatic run_and_check(input string tag, input bit disturb);
    int   cyc;
    int   extra;
    exp_t e;
    @(negedge clk);
    push_expected();
    start_select = 1'b1;
    @(negedge clk);
    start_select = 1'b0;
    cyc = 1;
    check({tag, "_busy_scan"}, 64'(busy), 64'd1);
    while (!select_done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (disturb && cyc == 2) begin
        start_select = 1'b1;
        lm[0] = -48'sd5000;
        la[0] = 10'd7;
        lc    = 4'd15;
      end else begin
        start_select = 1'b0;
      end
    end
    check({tag, "_done_seen"}, 64'(select_done), 64'd1);
    e = exp_q.pop_front();
    check({tag, "_latency"}, 64'(cyc), 64'(e.lat));
    check({tag, "_v0"}, 64'($unsigned(doa_value[0])), 64'(e.v0));
    check({tag, "_v1"}, 64'($unsigned(doa_value[1])), 64'(e.v1));
    check({tag, "_a0"}, 64'(doa_angle[0]), 64'(e.a0));
    check({tag, "_a1"}, 64'(doa_angle[1]), 64'(e.a1));
    check({tag, "_count"}, 64'(doa_count), 64'(e.c));
    if (disturb) start_select = 1'b1;
    @(negedge clk);
    start_select = 1'b0;
    check({tag, "_pulse_one_cycle"}, 64'(select_done), 64'd0);
    check({tag, "_idle_after"}, 64'(busy), 64'd0);
    if (disturb) begin
      extra = 0;
      for (int i = 0; i < 25; i++) begin
        @(negedge clk);
        if (select_done) extra++;
      end
      check({tag, "_no_extra_done"}, 64'(extra), 64'd0);
    end
  endtask

  initial begin
    int dones;
    rst          = 1'b1;
    start_select = 1'b0;
    lc           = '0;
    fill_junk();
    repeat (2) @(negedge clk);
    check("rst_v0", 64'($unsigned(doa_value[0])), 64'd0);
    check("rst_a1", 64'(doa_angle[1]), 64'd0);
    check("rst_count", 64'(doa_count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(select_done), 64'd0);
    rst = 1'b0;

    // Main case: [40,10,30,5,20] -> (5,30),(10,20), latency 7.
    fill_junk();
    set_entry(0, 48'sd40, 10'd15); set_entry(1, 48'sd10, 10'd20);
    set_entry(2, 48'sd30, 10'd25); set_entry(3, 48'sd5,  10'd30);
    set_entry(4, 48'sd20, 10'd35);
    lc = 4'd5;
    run_and_check("basic", 1'b0);

    // Ties keep list order.
    fill_junk();
    set_entry(0, 48'sd7, 10'd100); set_entry(1, 48'sd7, 10'd105); set_entry(2, 48'sd7, 10'd110);
    lc = 4'd3;
    run_and_check("ties", 1'b0);

    // Negative and wide values.
    fill_junk();
    set_entry(0, -48'sd1, 10'd1);
    set_entry(1, 48'sd70368744177664, 10'd2);
    set_entry(2, 48'sh8000_0000_0000, 10'd3);
    lc = 4'd3;
    run_and_check("wide", 1'b0);

    // Empty list.
    fill_junk();
    lc = 4'd0;
    run_and_check("empty", 1'b0);

    // Single candidate.
    fill_junk();
    set_entry(0, 48'sd9, 10'd50);
    lc = 4'd1;
    run_and_check("single", 1'b0);

    // Full list with descending values.
    fill_junk();
    for (int i = 0; i < 15; i++) set_entry(i, 48'(100 - 3 * i), 10'(i + 1));
    lc = 4'd15;
    run_and_check("full", 1'b0);

    // Snapshot robustness.
    fill_junk();
    set_entry(0, 48'sd12, 10'd11); set_entry(1, 48'sd3, 10'd22);
    set_entry(2, 48'sd8,  10'd33); set_entry(3, 48'sd3, 10'd44);
    lc = 4'd4;
    run_and_check("disturb", 1'b1);

    // Reset mid-SCAN clears outputs at once and suppresses select_done.
    fill_junk();
    set_entry(0, 48'sd4, 10'd9); set_entry(1, 48'sd6, 10'd8); set_entry(2, 48'sd2, 10'd7);
    lc = 4'd3;
    @(negedge clk);
    start_select = 1'b1;
    @(negedge clk);
    start_select = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_v0", 64'($unsigned(doa_value[0])), 64'd0);
    check("midrst_a0", 64'(doa_angle[0]), 64'd0);
    check("midrst_count", 64'(doa_count), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (select_done) dones++;
    end
    check("midrst_no_done", 64'(dones), 64'd0);

    // Fresh run after reset.
    run_and_check("after_rst", 1'b0);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
